execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline, directly downstream of the decode stage's ID/EX register.
- Takes ID/EX outputs, applies operand forwarding, computes the ALU result, resolves branches and jumps, and produces the redirect (PCSrcE, PCTargetE) for fetch and the hazard unit.
- Holds the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low: clears EX/MEM when rst==0 at a rising edge.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, JumpE, JumpRegE  in  1 each  ID/EX controls.
- funct3  in  3  branch condition / load-store size.
- ALUControlE  in  4  ALU operation.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN each  ID/EX data.
- RD_E  in  5  destination register.
- ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
- ResultW  in  XLEN  writeback result.
- ALUResultM_fwd  in  XLEN  EX/MEM result, looped back externally.
- PCSrcE  out  1  redirect taken (combinational).
- PCTargetE  out  XLEN  redirect address (combinational).
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered controls.
- funct3M  out  3  registered funct3.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  registered data.
- RD_M  out  5  registered destination register.

Behaviour:
- Forwarding: select 00 = RD1_E/RD2_E, 01 = ResultW, 10 = ALUResultM_fwd, 11 = same as 00. This gives SrcAE and WriteDataE.
- SrcBE = ALUSrcE ? Imm_Ext_E : WriteDataE.
- ALU, 32-bit wrap-around, no overflow flag:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount = SrcBE[4:0].
  - 1000 SLT (signed), 1001 SLTU; result is zero-extended 0/1.
  - 1010 pass SrcBE (LUI).
  - 1011 SrcBE + PCE (AUIPC).
  - All other codes produce 0.
- Branch compare always uses SrcAE vs WriteDataE, never SrcBE:
  - funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010, 011 never taken.
- PCSrcE = (BranchE & cond) | JumpE | JumpRegE.
- PCTargetE:
  - JumpRegE=1: (SrcAE + Imm_Ext_E) with bit 0 cleared.
  - Otherwise: PCE + Imm_Ext_E. Valid even when PCSrcE=0.
  - If JumpE and JumpRegE are both set, JumpRegE wins.
- Result into EX/MEM: if (JumpE|JumpRegE), ALUResultM <= PCPlus4E (link value); otherwise <= ALU output.
- EX/MEM register, updated every rising edge, latency 1 cycle:
  - When rst==0: all outputs <= 0, synchronously, regardless of other inputs.
  - Otherwise: RegWriteM, MemtoRegM, MemWriteM, funct3M, WriteDataM (forwarded), RD_M, PCPlus4M load from the E-side inputs.
- Bubble from decode (all controls 0, ALUControl 0000, data 0): produces ALUResultM=0, RegWriteM=0, MemWriteM=0, PCSrcE=0. No side effects.
- rst deasserted mid-stream: the first post-reset edge loads normally. PCSrcE/PCTargetE are purely combinational and not gated by rst.
- No stall input. The hazard unit stalls upstream and bubbles ID/EX.

Test Plan:
- Reset: rst=0 for 2 edges with non-zero inputs -> all M outputs 0. rst=1, RD1_E=5, RD2_E=7, ALUControlE=0000, ALUSrcE=0, RegWriteE=1, RD_E=3 -> next edge ALUResultM=12, RD_M=3, RegWriteM=1.
- Forwarding: RD1_E=1, ResultW=0x10, ALUResultM_fwd=0x20, RD2_E=2, ADD.
  - ForwardAE=01 -> ALUResultM=0x12.
  - ForwardAE=10 -> 0x22.
  - ForwardAE=11 -> 3.
  - ForwardBE=10 with MemWriteE=1 -> WriteDataM=0x20.
- Branches: PCE=0x100, Imm=0xFFFFFFF8, BranchE=1, RD1_E=0xFFFFFFFF, RD2_E=1.
  - funct3=100 -> PCSrcE=1, PCTargetE=0xF8.
  - funct3=110 -> PCSrcE=0.
  - funct3=000 -> 0.
  - funct3=010 -> 0.
- JALR: JumpRegE=1, RD1_E=0x203, Imm=2, PCPlus4E=0x44 -> PCSrcE=1, PCTargetE=0x204; next edge ALUResultM=0x44.
- ALU sweep:
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SRL -> 0x08000000.
  - SLT 0xFFFFFFFF,1 -> 1; SLTU -> 0.
  - SUB 0-1 -> 0xFFFFFFFF.
  - Code 1111 -> 0.
- Bubble: all-zero ID/EX inputs for 3 cycles -> PCSrcE=0, RegWriteM=MemWriteM=0, ALUResultM=0 each cycle.

Source files
------------

// File: rtl/execute_cycle_if.sv
// ID/EX inputs, forwarding sources, redirect outputs and EX/MEM register outputs of the execute stage.
interface execute_cycle_if #(parameter int XLEN = 32);
  logic            RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, JumpE, JumpRegE;
  logic [2:0]      funct3;
  logic [3:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]      RD_E;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] ResultW, ALUResultM_fwd;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM, MemtoRegM, MemWriteM;
  logic [2:0]      funct3M;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RD_M;

  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, JumpE, JumpRegE,
           funct3, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW, ALUResultM_fwd,
    input  PCSrcE, PCTargetE, RegWriteM, MemtoRegM, MemWriteM, funct3M,
           ALUResultM, WriteDataM, PCPlus4M, RD_M
  );

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, JumpE, JumpRegE,
           funct3, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW, ALUResultM_fwd,
    output PCSrcE, PCTargetE, RegWriteM, MemtoRegM, MemWriteM, funct3M,
           ALUResultM, WriteDataM, PCPlus4M, RD_M
  );
endinterface

// File: rtl/execute_cycle.sv
// RV32I execute stage: forwarding, ALU, branch/jump resolution (combinational redirect) and EX/MEM register.
// One-cycle latency into EX/MEM; no stall input, upstream hazard logic bubbles ID/EX instead.
module execute_cycle #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  execute_cycle_if.slave ex
);

  logic [XLEN-1:0] src_a, write_data, src_b, alu_out, jr_sum;
  logic [4:0]      shamt;
  logic            cond;

  always_comb begin
    src_a = ex.RD1_E;
    case (ex.ForwardAE)
      2'b01:   src_a = ex.ResultW;
      2'b10:   src_a = ex.ALUResultM_fwd;
      default: src_a = ex.RD1_E;
    endcase

    write_data = ex.RD2_E;
    case (ex.ForwardBE)
      2'b01:   write_data = ex.ResultW;
      2'b10:   write_data = ex.ALUResultM_fwd;
      default: write_data = ex.RD2_E;
    endcase
  end

  assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : write_data;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_out = '0;
    case (ex.ALUControlE)
      4'b0000: alu_out = src_a + src_b;
      4'b0001: alu_out = src_a - src_b;
      4'b0010: alu_out = src_a & src_b;
      4'b0011: alu_out = src_a | src_b;
      4'b0100: alu_out = src_a ^ src_b;
      4'b0101: alu_out = src_a << shamt;
      4'b0110: alu_out = src_a >> shamt;
      4'b0111: alu_out = $unsigned($signed(src_a) >>> shamt);
      4'b1000: alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1001: alu_out = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'b1010: alu_out = src_b;
      4'b1011: alu_out = src_b + ex.PCE;
      default: alu_out = '0;
    endcase
  end

  // Branch compare uses the register operands, never the immediate-muxed SrcB.
  always_comb begin
    cond = 1'b0;
    case (ex.funct3)
      3'b000:  cond = (src_a == write_data);
      3'b001:  cond = (src_a != write_data);
      3'b100:  cond = ($signed(src_a) < $signed(write_data));
      3'b101:  cond = ($signed(src_a) >= $signed(write_data));
      3'b110:  cond = (src_a < write_data);
      3'b111:  cond = (src_a >= write_data);
      default: cond = 1'b0;
    endcase
  end

  assign jr_sum       = src_a + ex.Imm_Ext_E;
  assign ex.PCSrcE    = (ex.BranchE & cond) | ex.JumpE | ex.JumpRegE;
  assign ex.PCTargetE = ex.JumpRegE ? {jr_sum[XLEN-1:1], 1'b0} : (ex.PCE + ex.Imm_Ext_E);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex.RegWriteM  <= 1'b0;
      ex.MemtoRegM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
      ex.funct3M    <= '0;
      ex.ALUResultM <= '0;
      ex.WriteDataM <= '0;
      ex.PCPlus4M   <= '0;
      ex.RD_M       <= '0;
    end else begin
      ex.RegWriteM  <= ex.RegWriteE;
      ex.MemtoRegM  <= ex.MemtoRegE;
      ex.MemWriteM  <= ex.MemWriteE;
      ex.funct3M    <= ex.funct3;
      ex.ALUResultM <= (ex.JumpE | ex.JumpRegE) ? ex.PCPlus4E : alu_out;
      ex.WriteDataM <= write_data;
      ex.PCPlus4M   <= ex.PCPlus4E;
      ex.RD_M       <= ex.RD_E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed vectors for the execute stage; driver queues expectations, a negedge monitor checks them.
module tb_execute_cycle;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_cycle_if #(.XLEN(32)) bus ();
  execute_cycle #(.XLEN(32)) dut (.clk(clk), .rst(rst), .ex(bus));

  typedef struct {
    int          id;
    logic        rst;
    logic        regw, mtr, memw, alusrc, br, j, jr;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [31:0] rd1, rd2, imm, pce, pc4, resw, fwd;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
    bit          c_pc, c_res, c_wd, c_ctl, c_pc4;
    logic        e_pcsrc;
    logic [31:0] e_tgt, e_res, e_wd, e_pc4;
    logic        e_regw, e_memw, e_mtr;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;
  } vec_t;

  vec_t exp_q[$];
  vec_t pend;
  bit   have_pend = 0;
  int   checks = 0;
  int   errors = 0;
  int   nvec = 0;

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  function automatic vec_t bub();
    vec_t v;
    v = '{default: '0};
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic issue(vec_t v);
    @(posedge clk);
    #1;
    v.id = nvec;
    nvec++;
    rst                = v.rst;
    bus.RegWriteE      = v.regw;
    bus.MemtoRegE      = v.mtr;
    bus.MemWriteE      = v.memw;
    bus.ALUSrcE        = v.alusrc;
    bus.BranchE        = v.br;
    bus.JumpE          = v.j;
    bus.JumpRegE       = v.jr;
    bus.funct3         = v.f3;
    bus.ALUControlE    = v.alu;
    bus.RD1_E          = v.rd1;
    bus.RD2_E          = v.rd2;
    bus.Imm_Ext_E      = v.imm;
    bus.PCE            = v.pce;
    bus.PCPlus4E       = v.pc4;
    bus.RD_E           = v.rd;
    bus.ForwardAE      = v.fa;
    bus.ForwardBE      = v.fb;
    bus.ResultW        = v.resw;
    bus.ALUResultM_fwd = v.fwd;
    exp_q.push_back(v);
  endtask

  // Registered results of the previous vector are due at this negedge; redirect of the newest one is live now.
  initial begin
    forever begin
      @(negedge clk);
      if (have_pend) begin
        if (pend.c_res) chk("ALUResultM", pend.id, bus.ALUResultM, pend.e_res);
        if (pend.c_wd)  chk("WriteDataM", pend.id, bus.WriteDataM, pend.e_wd);
        if (pend.c_pc4) chk("PCPlus4M", pend.id, bus.PCPlus4M, pend.e_pc4);
        if (pend.c_ctl) begin
          chk("RegWriteM", pend.id, {31'd0, bus.RegWriteM}, {31'd0, pend.e_regw});
          chk("MemWriteM", pend.id, {31'd0, bus.MemWriteM}, {31'd0, pend.e_memw});
          chk("MemtoRegM", pend.id, {31'd0, bus.MemtoRegM}, {31'd0, pend.e_mtr});
          chk("RD_M", pend.id, {27'd0, bus.RD_M}, {27'd0, pend.e_rd});
          chk("funct3M", pend.id, {29'd0, bus.funct3M}, {29'd0, pend.e_f3});
        end
        have_pend = 0;
      end
      if (exp_q.size() > 0) begin
        pend = exp_q.pop_front();
        have_pend = 1;
        if (pend.c_pc) begin
          chk("PCSrcE", pend.id, {31'd0, bus.PCSrcE}, {31'd0, pend.e_pcsrc});
          chk("PCTargetE", pend.id, bus.PCTargetE, pend.e_tgt);
        end
      end
    end
  end

  initial begin
    vec_t v;
    vec_t b;
    int   waited;

    // Reset held with live inputs: everything registered must stay zero.
    for (int i = 0; i < 2; i++) begin
      v = bub();
      v.rst = 1'b0; v.regw = 1; v.memw = 1; v.mtr = 1; v.rd1 = 5; v.rd2 = 7; v.rd = 3;
      v.f3 = 3'b010; v.pc4 = 32'h44;
      v.c_pc = 1; v.e_pcsrc = 0; v.e_tgt = 0;
      v.c_res = 1; v.c_wd = 1; v.c_ctl = 1; v.c_pc4 = 1;
      v.e_res = 0; v.e_wd = 0; v.e_pc4 = 0; v.e_regw = 0; v.e_memw = 0; v.e_mtr = 0; v.e_rd = 0; v.e_f3 = 0;
      issue(v);
    end

    v = bub();
    v.rd1 = 5; v.rd2 = 7; v.regw = 1; v.rd = 3;
    v.c_res = 1; v.e_res = 12; v.c_wd = 1; v.e_wd = 7;
    v.c_ctl = 1; v.e_regw = 1; v.e_memw = 0; v.e_mtr = 0; v.e_rd = 3; v.e_f3 = 0;
    issue(v);

    // Forwarding.
    b = bub();
    b.rd1 = 1; b.rd2 = 2; b.resw = 32'h10; b.fwd = 32'h20; b.regw = 1; b.rd = 5;
    b.c_res = 1; b.c_wd = 1; b.e_wd = 2;
    v = b; v.fa = 2'b01; v.e_res = 32'h12; issue(v);
    v = b; v.fa = 2'b10; v.e_res = 32'h22; issue(v);
    v = b; v.fa = 2'b11; v.e_res = 32'h3;  issue(v);
    v = b; v.fb = 2'b10; v.memw = 1; v.e_res = 32'h21; v.e_wd = 32'h20;
    v.c_ctl = 1; v.e_regw = 1; v.e_memw = 1; v.e_mtr = 0; v.e_rd = 5; v.e_f3 = 0;
    issue(v);

    // Branches: -1 vs 1, target 0x100 - 8.
    b = bub();
    b.pce = 32'h100; b.imm = 32'hFFFF_FFF8; b.br = 1; b.rd1 = 32'hFFFF_FFFF; b.rd2 = 1;
    b.c_pc = 1; b.e_tgt = 32'hF8; b.c_res = 1; b.e_res = 0;
    v = b; v.f3 = 3'b100; v.e_pcsrc = 1; issue(v);
    v = b; v.f3 = 3'b110; v.e_pcsrc = 0; issue(v);
    v = b; v.f3 = 3'b000; v.e_pcsrc = 0; issue(v);
    v = b; v.f3 = 3'b010; v.e_pcsrc = 0;
    v.c_ctl = 1; v.e_regw = 0; v.e_memw = 0; v.e_mtr = 0; v.e_rd = 0; v.e_f3 = 3'b010;
    issue(v);
    v = b; v.f3 = 3'b111; v.e_pcsrc = 1; issue(v);
    v = b; v.f3 = 3'b001; v.e_pcsrc = 1; issue(v);
    v = b; v.f3 = 3'b101; v.e_pcsrc = 0; issue(v);

    // JALR, JAL, and both jump flags set.
    v = bub();
    v.jr = 1; v.rd1 = 32'h203; v.imm = 2; v.pc4 = 32'h44; v.pce = 32'h100; v.alusrc = 1; v.regw = 1; v.rd = 1;
    v.c_pc = 1; v.e_pcsrc = 1; v.e_tgt = 32'h204; v.c_res = 1; v.e_res = 32'h44; v.c_pc4 = 1; v.e_pc4 = 32'h44;
    issue(v);
    v = bub();
    v.j = 1; v.pce = 32'h100; v.imm = 32'h20; v.pc4 = 32'h104;
    v.c_pc = 1; v.e_pcsrc = 1; v.e_tgt = 32'h120; v.c_res = 1; v.e_res = 32'h104;
    issue(v);
    v = bub();
    v.j = 1; v.jr = 1; v.rd1 = 32'h300; v.imm = 32'h10; v.pce = 32'h100; v.pc4 = 32'h104;
    v.c_pc = 1; v.e_pcsrc = 1; v.e_tgt = 32'h310; v.c_res = 1; v.e_res = 32'h104;
    issue(v);

    // ALU sweep.
    v = bub(); v.alu = 4'b0111; v.alusrc = 1; v.rd1 = 32'h8000_0000; v.imm = 4;
    v.c_res = 1; v.e_res = 32'hF800_0000; issue(v);
    v.alu = 4'b0110; v.e_res = 32'h0800_0000; issue(v);
    v = bub(); v.alu = 4'b1000; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.c_res = 1; v.e_res = 1; issue(v);
    v.alu = 4'b1001; v.e_res = 0; issue(v);
    v = bub(); v.alu = 4'b0001; v.rd1 = 0; v.rd2 = 1; v.c_res = 1; v.e_res = 32'hFFFF_FFFF; issue(v);
    v = bub(); v.alu = 4'b1111; v.rd1 = 5; v.rd2 = 3; v.c_res = 1; v.e_res = 0; issue(v);
    v = bub(); v.alu = 4'b0101; v.alusrc = 1; v.rd1 = 1; v.imm = 32'h23; v.c_res = 1; v.e_res = 8; issue(v);
    v = bub(); v.alu = 4'b1010; v.alusrc = 1; v.rd1 = 32'h55; v.imm = 32'h1234_5000;
    v.c_res = 1; v.e_res = 32'h1234_5000; issue(v);
    v = bub(); v.alu = 4'b1011; v.alusrc = 1; v.imm = 32'h1000; v.pce = 32'h200;
    v.c_res = 1; v.e_res = 32'h1200; issue(v);
    v = bub(); v.rd1 = 32'hF0F0; v.rd2 = 32'hFF00; v.c_res = 1;
    v.alu = 4'b0010; v.e_res = 32'hF000; issue(v);
    v.alu = 4'b0011; v.e_res = 32'hFFF0; issue(v);
    v.alu = 4'b0100; v.e_res = 32'h0FF0; issue(v);

    // Bubbles.
    for (int i = 0; i < 3; i++) begin
      v = bub();
      v.c_pc = 1; v.e_pcsrc = 0; v.e_tgt = 0;
      v.c_res = 1; v.e_res = 0; v.c_wd = 1; v.e_wd = 0;
      v.c_ctl = 1; v.e_regw = 0; v.e_memw = 0; v.e_mtr = 0; v.e_rd = 0; v.e_f3 = 0;
      issue(v);
    end

    // Reset pulse mid-stream, then the first edge after it loads normally.
    v = bub();
    v.rst = 1'b0; v.regw = 1; v.rd1 = 9; v.rd2 = 9; v.rd = 7; v.br = 1;
    v.c_pc = 1; v.e_pcsrc = 1; v.e_tgt = 0;
    v.c_res = 1; v.e_res = 0; v.c_ctl = 1; v.e_regw = 0; v.e_memw = 0; v.e_mtr = 0; v.e_rd = 0; v.e_f3 = 0;
    issue(v);
    v = bub();
    v.rd1 = 5; v.rd2 = 7; v.regw = 1; v.rd = 3;
    v.c_res = 1; v.e_res = 12; v.c_ctl = 1; v.e_regw = 1; v.e_memw = 0; v.e_mtr = 0; v.e_rd = 3; v.e_f3 = 0;
    issue(v);

    waited = 0;
    while ((exp_q.size() > 0 || have_pend) && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0 || have_pend) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
